// File: rtl/rld_pkg.sv
// Shared defaults, sizing helpers and code layout for the multi-channel
// run-length decoder.
package rld_pkg;

    localparam int unsigned CH_DEF    = 3;
    localparam int unsigned PIX_W_DEF = 8;
    localparam int unsigned CNT_W_DEF = 8;
    localparam int unsigned DEPTH_DEF = 16;
    localparam int unsigned IMG_W_DEF = 128;
    localparam int unsigned IMG_H_DEF = 128;

    function automatic int unsigned code_w(input int unsigned cnt_w, input int unsigned pix_w);
        return cnt_w + pix_w;
    endfunction

    // Ceiling log2, never below 1 so degenerate sizes still get a real register.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    localparam int unsigned CODE_W_DEF = code_w(CNT_W_DEF, PIX_W_DEF);

    typedef struct packed {
        logic [CNT_W_DEF-1:0] count;
        logic [PIX_W_DEF-1:0] pixel;
    } code_t;

endpackage

// File: rtl/rld_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is visible on
// head_c whenever empty is low.
module rld_fifo import rld_pkg::*; #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] head_c,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             push;
    logic             pop;

    assign push   = wr_en & ~full;
    assign pop    = rd_en & ~empty;
    assign head_c = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Flags are registered from the next occupancy so they never glitch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/rld_multi.sv
// N-channel run-length decoder: each channel buffers {count, pixel} codes and
// expands them into a backpressured pixel stream with row/frame markers.
module rld_multi import rld_pkg::*; #(
    parameter  int unsigned CH     = CH_DEF,
    parameter  int unsigned PIX_W  = PIX_W_DEF,
    parameter  int unsigned CNT_W  = CNT_W_DEF,
    parameter  int unsigned DEPTH  = DEPTH_DEF,
    parameter  int unsigned IMG_W  = IMG_W_DEF,
    parameter  int unsigned IMG_H  = IMG_H_DEF,
    localparam int unsigned CODE_W = code_w(CNT_W, PIX_W)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic [CH-1:0]       start,
    input  logic [CH-1:0]       code_valid,
    input  logic [CH*CODE_W-1:0] code_data,
    output logic [CH-1:0]       code_ready,
    output logic [CH-1:0]       pix_valid,
    output logic [CH*PIX_W-1:0] pix_data,
    input  logic [CH-1:0]       pix_ready,
    output logic [CH-1:0]       row_end,
    output logic [CH-1:0]       frame_end,
    output logic [CH-1:0]       done
);

    localparam int unsigned COL_W = clog2(IMG_W);
    localparam int unsigned ROW_W = clog2(IMG_H);

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic              fifo_full;
        logic              fifo_empty;
        logic [CODE_W-1:0] head;
        logic [CNT_W-1:0]  head_cnt;
        logic [PIX_W-1:0]  head_pix;
        logic [CNT_W-1:0]  in_cnt;
        logic              rdy;
        logic              wr;
        logic              pop;
        logic              valid;
        logic              xfer;
        logic              last_col;
        logic              last_row;
        logic              eof;
        logic [CNT_W-1:0]  rem;
        logic [PIX_W-1:0]  cur;
        logic [COL_W-1:0]  col;
        logic [ROW_W-1:0]  row;
        logic              done_q;

        // Zero-count codes are handshaken but never stored.
        assign in_cnt = code_data[c*CODE_W+PIX_W +: CNT_W];
        assign rdy    = rst & start[c] & ~fifo_full & ~done_q & ~clear;
        assign wr     = code_valid[c] & rdy & (in_cnt != '0);

        rld_fifo #(.WIDTH(CODE_W), .DEPTH(DEPTH)) u_fifo (
            .clk    (clk),
            .rst    (rst),
            .clear  (clear),
            .wr_en  (wr),
            .wr_data(code_data[c*CODE_W +: CODE_W]),
            .rd_en  (pop),
            .head_c (head),
            .full   (fifo_full),
            .empty  (fifo_empty)
        );

        assign {head_cnt, head_pix} = head;

        assign valid    = (rem != '0) & ~done_q;
        assign xfer     = valid & pix_ready[c];
        assign last_col = (col == COL_W'(IMG_W - 1));
        assign last_row = (row == ROW_W'(IMG_H - 1));
        assign eof      = valid & last_col & last_row;

        // Reload on an idle decoder or on the final pixel of a run for gapless output.
        assign pop = ~clear & ~done_q & ~fifo_empty & ~(xfer & eof)
                   & ((rem == '0) | (xfer & (rem == CNT_W'(1))));

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rem    <= '0;
                cur    <= '0;
                col    <= '0;
                row    <= '0;
                done_q <= 1'b0;
            end else if (clear) begin
                rem    <= '0;
                cur    <= '0;
                col    <= '0;
                row    <= '0;
                done_q <= 1'b0;
            end else begin
                if (pop) begin
                    rem <= head_cnt;
                    cur <= head_pix;
                end else if (xfer & eof) begin
                    rem <= '0;
                end else if (xfer) begin
                    rem <= rem - CNT_W'(1);
                end

                if (xfer) begin
                    if (eof) begin
                        done_q <= 1'b1;
                        col    <= '0;
                        row    <= '0;
                    end else if (last_col) begin
                        col <= '0;
                        row <= row + ROW_W'(1);
                    end else begin
                        col <= col + COL_W'(1);
                    end
                end
            end
        end

        assign code_ready[c]               = rdy;
        assign pix_valid[c]                = valid;
        assign pix_data[c*PIX_W +: PIX_W]  = cur;
        assign row_end[c]                  = valid & last_col;
        assign frame_end[c]                = eof;
        assign done[c]                     = done_q;
    end

endmodule

// File: tb/tb_rld_multi.sv
// Bench for rld_multi: queue-based channel model checked every cycle, plus
// directed scenarios with literal expectations on channel 0.
module tb_rld_multi;
    import rld_pkg::*;

    localparam int CH     = 3;
    localparam int PIX_W  = 8;
    localparam int CNT_W  = 8;
    localparam int CODE_W = 16;
    localparam int DEPTH  = 4;
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 clear = 1'b0;
    logic [CH-1:0]        start = '0;
    logic [CH-1:0]        code_valid = '0;
    logic [CH*CODE_W-1:0] code_data = '0;
    logic [CH-1:0]        pix_ready = '0;
    logic [CH-1:0]        code_ready;
    logic [CH-1:0]        pix_valid;
    logic [CH*PIX_W-1:0]  pix_data;
    logic [CH-1:0]        row_end;
    logic [CH-1:0]        frame_end;
    logic [CH-1:0]        done;

    always #5 clk = ~clk;

    rld_multi #(
        .CH(CH), .PIX_W(PIX_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .IMG_W(IMG_W), .IMG_H(IMG_H)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear), .start(start),
        .code_valid(code_valid), .code_data(code_data), .code_ready(code_ready),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .row_end(row_end), .frame_end(frame_end), .done(done)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Channel model: pending runs in a queue, current run, linear pixel index in the frame.
    logic [CODE_W-1:0] m_q [CH][$];
    int                m_rem  [CH];
    int                m_idx  [CH];
    logic [PIX_W-1:0]  m_cur  [CH];
    bit                m_done [CH];

    function automatic bit e_valid(input int c);
        return (m_rem[c] != 0) && !m_done[c];
    endfunction

    function automatic bit e_row_end(input int c);
        return e_valid(c) && ((m_idx[c] % IMG_W) == IMG_W - 1);
    endfunction

    function automatic bit e_frame_end(input int c);
        return e_valid(c) && (m_idx[c] == IMG_W * IMG_H - 1);
    endfunction

    function automatic bit e_ready(input int c);
        return rst && start[c] && (m_q[c].size() < DEPTH) && !m_done[c] && !clear;
    endfunction

    always @(posedge clk or negedge rst) begin : model
        bit                xf;
        bit                fe;
        bit                ld;
        bit                wr;
        logic [CODE_W-1:0] cd;
        logic [CODE_W-1:0] hd;
        if (!rst) begin
            for (int c = 0; c < CH; c++) begin
                m_q[c].delete();
                m_rem[c]  <= 0;
                m_idx[c]  <= 0;
                m_cur[c]  <= '0;
                m_done[c] <= 1'b0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (clear) begin
                    m_q[c].delete();
                    m_rem[c]  <= 0;
                    m_idx[c]  <= 0;
                    m_cur[c]  <= '0;
                    m_done[c] <= 1'b0;
                end else begin
                    xf = e_valid(c) && pix_ready[c];
                    fe = e_frame_end(c);
                    wr = code_valid[c] && e_ready(c);
                    cd = code_data[c*CODE_W +: CODE_W];
                    ld = !m_done[c] && (m_q[c].size() > 0) && !(xf && fe)
                         && ((m_rem[c] == 0) || (xf && m_rem[c] == 1));
                    if (ld) begin
                        hd = m_q[c].pop_front();
                        m_rem[c] <= int'(hd[CODE_W-1:PIX_W]);
                        m_cur[c] <= hd[PIX_W-1:0];
                    end else if (xf) begin
                        m_rem[c] <= fe ? 0 : m_rem[c] - 1;
                    end
                    if (xf) begin
                        if (fe) begin
                            m_idx[c]  <= 0;
                            m_done[c] <= 1'b1;
                        end else begin
                            m_idx[c] <= m_idx[c] + 1;
                        end
                    end
                    if (wr && cd[CODE_W-1:PIX_W] != '0) m_q[c].push_back(cd);
                end
            end
        end
    end

    // Channel-0 transfer log for the directed scenarios.
    logic [PIX_W-1:0] log_d [$];
    logic [1:0]       log_f [$];
    int               log_t [$];

    always @(negedge clk) begin : cmp
        logic [CH-1:0] ev;
        logic [CH-1:0] er;
        logic [CH-1:0] ere;
        logic [CH-1:0] efe;
        logic [CH-1:0] ed;
        for (int c = 0; c < CH; c++) begin
            ev[c]  = e_valid(c);
            er[c]  = e_ready(c);
            ere[c] = e_row_end(c);
            efe[c] = e_frame_end(c);
            ed[c]  = m_done[c];
        end
        check("pix_valid",  32'(pix_valid),  32'(ev));
        check("code_ready", 32'(code_ready), 32'(er));
        check("row_end",    32'(row_end),    32'(ere));
        check("frame_end",  32'(frame_end),  32'(efe));
        check("done",       32'(done),       32'(ed));
        for (int c = 0; c < CH; c++) begin
            if (ev[c]) check("pix_data", 32'(pix_data[c*PIX_W +: PIX_W]), 32'(m_cur[c]));
        end
        if (pix_valid[0] && pix_ready[0]) begin
            log_d.push_back(pix_data[PIX_W-1:0]);
            log_f.push_back({row_end[0], frame_end[0]});
            log_t.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_log();
        log_d.delete();
        log_f.delete();
        log_t.delete();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic send(input int c, input int cnt, input int pix);
        bit    ok;
        code_t cd;
        ok = 1'b0;
        cd.count = 8'(cnt);
        cd.pixel = 8'(pix);
        code_data[c*CODE_W +: CODE_W] = cd;
        code_valid[c] = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            ok = code_ready[c];
            if (ok) last_acc = cyc;
            tick();
        end
        code_valid[c] = 1'b0;
        check("send_accept", 32'(ok), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        start = '1;
        repeat (3) tick();
        check("reset_code_ready", 32'(code_ready), 32'd0);
        check("reset_pix_valid",  32'(pix_valid),  32'd0);
        check("reset_done",       32'(done),       32'd0);
        check("reset_pix_data",   32'(pix_data),   32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(code_ready), 32'h7);
        tick();

        // Single run of three.
        pix_ready = '1;
        flush_log();
        send(0, 3, 8'hAA);
        repeat (8) tick();
        check("t1_count", 32'(log_d.size()), 32'd3);
        for (int i = 0; i < log_d.size(); i++) check("t1_data", 32'(log_d[i]), 32'hAA);
        if (log_d.size() == 3) begin
            check("t1_latency", 32'(log_t[0]), 32'(last_acc + 2));
            check("t1_contig",  32'(log_t[2]), 32'(log_t[0] + 2));
        end

        // Back-to-back runs without a bubble.
        pulse_clear();
        flush_log();
        send(0, 2, 8'h11);
        send(0, 1, 8'h22);
        repeat (8) tick();
        check("t2_count", 32'(log_d.size()), 32'd3);
        if (log_d.size() == 3) begin
            check("t2_d0", 32'(log_d[0]), 32'h11);
            check("t2_d1", 32'(log_d[1]), 32'h11);
            check("t2_d2", 32'(log_d[2]), 32'h22);
            check("t2_contig", 32'(log_t[2]), 32'(log_t[0] + 2));
        end
        check("t2_idle", 32'(pix_valid[0]), 32'd0);

        // Zero-count code is dropped.
        pulse_clear();
        flush_log();
        send(0, 0, 8'h55);
        send(0, 1, 8'h66);
        repeat (6) tick();
        check("t3_count", 32'(log_d.size()), 32'd1);
        if (log_d.size() == 1) check("t3_data", 32'(log_d[0]), 32'h66);

        // Backpressure fills the FIFO, then a toggling sink drains it in order.
        pulse_clear();
        flush_log();
        pix_ready[0] = 1'b0;
        for (int i = 0; i < 5; i++) send(0, 1, 8'h31 + i);
        @(negedge clk);
        check("t4_full_ready", 32'(code_ready[0]), 32'd0);
        check("t4_head_valid", 32'(pix_valid[0]), 32'd1);
        check("t4_head_data",  32'(pix_data[PIX_W-1:0]), 32'h31);
        tick();
        for (int i = 0; i < 40 && log_d.size() < 5; i++) begin
            pix_ready[0] = ~pix_ready[0];
            tick();
        end
        check("t4_count", 32'(log_d.size()), 32'd5);
        for (int i = 0; i < log_d.size(); i++) check("t4_order", 32'(log_d[i]), 32'(8'h31 + i));

        // Run longer than a frame: markers, done, then clear.
        pulse_clear();
        flush_log();
        pix_ready = '1;
        send(0, 10, 8'h07);
        repeat (14) tick();
        check("t5_count", 32'(log_d.size()), 32'd8);
        for (int i = 0; i < log_d.size(); i++) begin
            check("t5_data",  32'(log_d[i]), 32'h07);
            check("t5_flags", 32'(log_f[i]), (i == 3) ? 32'h2 : (i == 7) ? 32'h3 : 32'h0);
        end
        check("t5_done",  32'(done[0]),       32'd1);
        check("t5_ready", 32'(code_ready[0]), 32'd0);
        check("t5_valid", 32'(pix_valid[0]),  32'd0);
        pulse_clear();
        @(negedge clk);
        check("t5_clr_done",  32'(done[0]),       32'd0);
        check("t5_clr_ready", 32'(code_ready[0]), 32'd1);
        tick();

        // Randomised traffic on all channels.
        for (int i = 0; i < 1500; i++) begin
            start      = 3'($urandom) | 3'($urandom);
            code_valid = 3'($urandom);
            pix_ready  = 3'($urandom) | 3'($urandom);
            clear      = ($urandom_range(0, 39) == 0);
            for (int c = 0; c < CH; c++) begin
                code_data[c*CODE_W +: CODE_W] = {8'($urandom_range(0, 5)), 8'($urandom)};
            end
            tick();
        end

        // Asynchronous reset mid-run.
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("t6_rst_valid", 32'(pix_valid),  32'd0);
        check("t6_rst_done",  32'(done),       32'd0);
        check("t6_rst_ready", 32'(code_ready), 32'd0);
        clear      = 1'b0;
        code_valid = '0;
        start      = '1;
        pix_ready  = '1;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        flush_log();
        send(0, 4, 8'h9C);
        repeat (8) tick();
        check("t6_count", 32'(log_d.size()), 32'd4);
        for (int i = 0; i < log_d.size(); i++) begin
            check("t6_data",  32'(log_d[i]), 32'h9C);
            check("t6_flags", 32'(log_f[i]), (i == 3) ? 32'h2 : 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
